// File: rtl/wrr_pkg.sv
// Shared defaults and entry layout for the WRR grant dispatch slice.
package wrr_pkg;
   localparam int unsigned WRR_N     = 8;
   localparam int unsigned WRR_DW    = 32;
   localparam int unsigned WRR_DEPTH = 4;

   localparam int unsigned IDW = $clog2(WRR_N);
   localparam int unsigned CW  = $clog2(WRR_DEPTH) + 1;

   typedef struct packed {
      logic [IDW-1:0]    id;
      logic [WRR_DW-1:0] data;
   } wrr_entry_t;
endpackage

// File: rtl/wrr_dispatch_fifo.sv
// Generic first-word-fall-through FIFO; head is always visible on o_dout.
module wrr_dispatch_fifo #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rstn,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [W-1:0]             i_din,
   output logic [W-1:0]             o_dout,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);
   localparam int unsigned PW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wptr_q, rptr_q;
   logic [PW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign o_full  = (count_q == (PW+1)'(DEPTH));
   assign o_empty = (count_q == '0);

   // A push into a full FIFO is legal only when the head leaves in the same cycle.
   assign do_pop  = i_pop && !o_empty;
   assign do_push = i_push && (!o_full || do_pop);

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wptr_q] <= i_din;
            wptr_q        <= wptr_q + 1'b1;
         end
         if (do_pop) rptr_q <= rptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   assign o_dout  = mem_q[rptr_q];
   assign o_count = count_q;
endmodule

// File: rtl/wrr_grant_dispatch.sv
// Converts the arbiter's one-hot grant into a queued {id, payload} stream with
// per-requester ack, arbiter back-pressure and sticky malformed-grant flags.
module wrr_grant_dispatch
   import wrr_pkg::*;
#(
   parameter int unsigned N     = WRR_N,
   parameter int unsigned DW    = WRR_DW,
   parameter int unsigned DEPTH = WRR_DEPTH
) (
   input  logic                      i_clk,
   input  logic                      i_rstn,
   input  logic [N-1:0]              i_gnt,
   input  logic [N*DW-1:0]           i_data,
   output logic                      o_arb_en,
   output logic [N-1:0]              o_ack,
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic [DW-1:0]             o_data,
   output logic [$clog2(N)-1:0]      o_id,
   output logic [$clog2(DEPTH):0]    o_count,
   output logic                      o_err_multi,
   output logic                      o_err_ovf,
   input  logic                      i_clr_err
);
   localparam int unsigned ID_W  = $clog2(N);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   // Local entry type so non-default N/DW still pack correctly.
   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [DW-1:0]   data;
   } entry_t;

   logic [ID_W-1:0]  idx;
   logic [DW-1:0]    lane;
   logic             one_hot, multi_hot;
   logic             push, pop, room, ovf;
   logic             fifo_full, fifo_empty;
   logic [CNT_W-1:0] count;
   entry_t           wr_entry, rd_entry;

   logic [N-1:0]     ack_q;
   logic             err_multi_q, err_ovf_q;

   always_comb begin
      idx  = '0;
      lane = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (i_gnt[i]) begin
            idx  = ID_W'(i);
            lane = i_data[i*DW +: DW];
         end
      end
   end

   assign one_hot   = (i_gnt != '0) && ((i_gnt & (i_gnt - 1'b1)) == '0);
   assign multi_hot = (i_gnt != '0) && !one_hot;

   assign pop  = !fifo_empty && i_ready;
   assign room = !fifo_full || pop;
   assign push = one_hot && room;
   assign ovf  = one_hot && !room;

   assign wr_entry = '{id: idx, data: lane};

   wrr_dispatch_fifo #(
      .W     ($bits(entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_push  (push),
      .i_pop   (pop),
      .i_din   (wr_entry),
      .o_dout  (rd_entry),
      .o_count (count),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

   // A new error in the clearing cycle keeps the bit set.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         ack_q       <= '0;
         err_multi_q <= 1'b0;
         err_ovf_q   <= 1'b0;
      end else begin
         ack_q       <= push ? i_gnt : '0;
         err_multi_q <= multi_hot || (err_multi_q && !i_clr_err);
         err_ovf_q   <= ovf || (err_ovf_q && !i_clr_err);
      end
   end

   assign o_arb_en    = (count <= CNT_W'(DEPTH - 2));
   assign o_ack       = ack_q;
   assign o_valid     = !fifo_empty;
   assign o_data      = rd_entry.data;
   assign o_id        = rd_entry.id;
   assign o_count     = count;
   assign o_err_multi = err_multi_q;
   assign o_err_ovf   = err_ovf_q;
endmodule
